// File: rtl/seg_display_arbiter.sv
// Two-client arbiter for the shared 8-digit multiplexed 7-segment display.
// Client 1 has priority, owners keep a minimum hold, and every handover is blanked for a fixed gap.
module seg_display_arbiter #(
    parameter int SCAN_DIV    = 50000,
    parameter int HOLD_CYCLES = 100000000,
    parameter int GAP_CYCLES  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    input  logic [7:0]  blank0,
    input  logic [7:0]  blank1,
    output logic [1:0]  grant,
    output logic [7:0]  seg_out,
    output logic [7:0]  digit_sel,
    output logic        switch_pulse
);

    localparam int SCAN_W = (SCAN_DIV > 1)    ? $clog2(SCAN_DIV)    : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1)  ? $clog2(GAP_CYCLES)  : 1;

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GAP  = 2'd1;
    localparam logic [1:0] S_OWN0 = 2'd2;
    localparam logic [1:0] S_OWN1 = 2'd3;

    logic [1:0]        state, state_nxt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [SCAN_W-1:0] scan_cnt;
    logic [2:0]        idx;

    logic        in_own;
    logic        own_stay;
    logic        own_enter;
    logic [31:0] own_data;
    logic [7:0]  own_blank;
    logic [3:0]  own_nibble;

    function automatic logic [7:0] decode(input logic [3:0] nib, input logic dark);
        logic [7:0] s;
        s = 8'h40;
        if (dark) begin
            s = 8'h00;
        end else begin
            case (nib)
                4'd0:    s = 8'h3F;
                4'd1:    s = 8'h06;
                4'd2:    s = 8'h5B;
                4'd3:    s = 8'h4F;
                4'd4:    s = 8'h66;
                4'd5:    s = 8'h6D;
                4'd6:    s = 8'h7D;
                4'd7:    s = 8'h07;
                4'd8:    s = 8'h7F;
                4'd9:    s = 8'h6F;
                default: s = 8'h40;
            endcase
        end
        return s;
    endfunction

    // Owner drop is checked before preemption so a simultaneous drop+preempt is a plain drop.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req1 || req0) state_nxt = S_GAP;
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    if (req1)      state_nxt = S_OWN1;
                    else if (req0) state_nxt = S_OWN0;
                    else           state_nxt = S_IDLE;
                end
            end
            S_OWN0: begin
                if (!req0)                               state_nxt = S_GAP;
                else if (req1 && (hold_cnt == HOLD_LAST)) state_nxt = S_GAP;
            end
            S_OWN1: begin
                if (!req1) state_nxt = S_GAP;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign in_own     = (state == S_OWN0) || (state == S_OWN1);
    assign own_stay   = in_own && (state_nxt == state);
    assign own_enter  = (state == S_GAP) && ((state_nxt == S_OWN0) || (state_nxt == S_OWN1));
    assign own_data   = (state == S_OWN1) ? data1  : data0;
    assign own_blank  = (state == S_OWN1) ? blank1 : blank0;
    assign own_nibble = own_data[{idx, 2'b00} +: 4];

    always_comb begin
        case (state)
            S_OWN0:  grant = 2'b01;
            S_OWN1:  grant = 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            gap_cnt      <= '0;
            hold_cnt     <= '0;
            scan_cnt     <= '0;
            idx          <= 3'd0;
            seg_out      <= 8'h00;
            digit_sel    <= 8'h00;
            switch_pulse <= 1'b0;
        end else begin
            state        <= state_nxt;
            switch_pulse <= own_enter;

            if ((state == S_GAP) && (state_nxt == S_GAP))
                gap_cnt <= gap_cnt + GAP_W'(1);
            else
                gap_cnt <= '0;

            // Any cycle that is not a continuing ownership restarts the scan and blanks the bus.
            if (own_stay) begin
                if (hold_cnt != HOLD_LAST)
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                if (scan_cnt == SCAN_LAST) begin
                    scan_cnt  <= '0;
                    seg_out   <= decode(own_nibble, own_blank[idx]);
                    digit_sel <= 8'b1 << idx;
                    idx       <= idx + 3'd1;
                end else begin
                    scan_cnt <= scan_cnt + SCAN_W'(1);
                end
            end else begin
                hold_cnt  <= '0;
                scan_cnt  <= '0;
                idx       <= 3'd0;
                seg_out   <= 8'h00;
                digit_sel <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench: a per-cycle behavioural model queues expected outputs, a negedge monitor checks them.
module tb_seg_display_arbiter;

    localparam int SD = 4;
    localparam int HC = 20;
    localparam int GC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [31:0] data0 = '0, data1 = '0;
    logic [7:0]  blank0 = '0, blank1 = '0;
    logic [1:0]  grant;
    logic [7:0]  seg_out, digit_sel;
    logic        switch_pulse;

    seg_display_arbiter #(.SCAN_DIV(SD), .HOLD_CYCLES(HC), .GAP_CYCLES(GC)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .data0(data0), .data1(data1), .blank0(blank0), .blank1(blank1),
        .grant(grant), .seg_out(seg_out), .digit_sel(digit_sel), .switch_pulse(switch_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] grant;
        logic [7:0] seg;
        logic [7:0] dig;
        logic       pulse;
    } out_t;

    out_t exp_q[$];
    int total = 0;
    int bad = 0;

    logic [7:0] seg_tab[10];
    initial seg_tab = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    // Model: mode 0 idle, 1 gap, 2 owned; own_t = cycles elapsed since the grant appeared.
    int         m_mode = 0, m_owner = 0, m_gap_left = 0, m_t = 0;
    logic [7:0] m_seg = '0, m_dig = '0;
    logic       m_pulse = 1'b0;

    function automatic logic [7:0] ref_seg(input logic [31:0] d, input logic [7:0] b, input int i);
        logic [3:0] n;
        n = d[i*4 +: 4];
        if (b[i]) return 8'h00;
        if (n < 10) return seg_tab[n];
        return 8'h40;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int  i;
        logic orq;
        out_t e;
        if (!rst_n) begin
            m_mode = 0; m_owner = 0; m_gap_left = 0; m_t = 0;
            m_seg = '0; m_dig = '0; m_pulse = 1'b0;
            exp_q.delete();
        end else begin
            m_pulse = 1'b0;
            case (m_mode)
                0: if (req0 || req1) begin m_mode = 1; m_gap_left = GC; end
                1: begin
                    m_gap_left--;
                    if (m_gap_left == 0) begin
                        if (req1 || req0) begin
                            m_mode = 2; m_owner = req1 ? 1 : 0; m_t = 0;
                            m_pulse = 1'b1; m_seg = '0; m_dig = '0;
                        end else begin
                            m_mode = 0;
                        end
                    end
                end
                default: begin
                    orq = (m_owner == 1) ? req1 : req0;
                    if (!orq || (m_owner == 0 && req1 && m_t >= HC - 1)) begin
                        m_mode = 1; m_gap_left = GC; m_seg = '0; m_dig = '0;
                    end else begin
                        m_t++;
                        if (m_t % SD == 0) begin
                            i = (m_t / SD - 1) % 8;
                            m_seg = (m_owner == 1) ? ref_seg(data1, blank1, i) : ref_seg(data0, blank0, i);
                            m_dig = 8'(1 << i);
                        end
                    end
                end
            endcase
            e.grant = (m_mode == 2) ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
            e.seg   = m_seg;
            e.dig   = m_dig;
            e.pulse = m_pulse;
            exp_q.push_back(e);
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        out_t e, g;
        g = {grant, seg_out, digit_sel, switch_pulse};
        if (!rst_n || exp_q.size() == 0) e = '0;
        else e = exp_q.pop_front();
        chk("grant", 32'(g.grant), 32'(e.grant));
        chk("seg_out", 32'(g.seg), 32'(e.seg));
        chk("digit_sel", 32'(g.dig), 32'(e.dig));
        chk("switch_pulse", 32'(g.pulse), 32'(e.pulse));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input logic [1:0] g, input int max, input string nm);
        int n;
        n = 0;
        while (grant !== g && n < max) begin
            tick();
            n++;
        end
        chk(nm, 32'(grant), 32'(g));
    endtask

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Client 0 scan through a full wrap, then drop and re-request.
        data0 = 32'h76543210; blank0 = 8'h00; req0 = 1'b1;
        wait_grant(2'b01, 10, "first_grant0");
        repeat (40) tick();
        req0 = 1'b0;
        repeat (6) tick();
        req0 = 1'b1;
        wait_grant(2'b01, 10, "regrant0");

        // Preemption by client 1 after the hold time.
        data1 = 32'h8765B321; blank1 = 8'h04;
        repeat (4) tick();
        req1 = 1'b1;
        wait_grant(2'b10, 60, "preempt1");

        // Client 1 is never preempted by client 0.
        repeat (1000) tick();
        chk("own1_kept", 32'(grant), 32'(2'b10));
        req1 = 1'b0;
        wait_grant(2'b01, 10, "handback0");

        req1 = 1'b1;
        wait_grant(2'b10, 60, "preempt1_again");
        repeat (10) tick();

        // Asynchronous reset mid-scan.
        rst_n = 1'b0;
        #1;
        chk("async_grant", 32'(grant), 32'(2'b00));
        chk("async_seg", 32'(seg_out), 32'(8'h00));
        chk("async_dig", 32'(digit_sel), 32'(8'h00));
        repeat (2) tick();
        rst_n = 1'b1;
        wait_grant(2'b10, 10, "post_reset_own1");
        repeat (40) tick();

        // Simultaneous requests from idle, then simultaneous drop.
        req0 = 1'b0; req1 = 1'b0;
        repeat (10) tick();
        req0 = 1'b1; req1 = 1'b1;
        wait_grant(2'b10, 10, "both_req");
        req0 = 1'b0; req1 = 1'b0;
        repeat (10) tick();
        chk("both_drop_idle", 32'(grant), 32'(2'b00));

        // Randomized traffic, including mid-slot data changes.
        for (int k = 0; k < 4000; k++) begin
            tick();
            if ($urandom_range(0, 39) == 0) req0 = ~req0;
            if ($urandom_range(0, 59) == 0) req1 = ~req1;
            if ($urandom_range(0, 5) == 0) data0 = $urandom;
            if ($urandom_range(0, 5) == 0) data1 = $urandom;
            if ($urandom_range(0, 15) == 0) blank0 = 8'($urandom & $urandom);
            if ($urandom_range(0, 15) == 0) blank1 = 8'($urandom & $urandom);
        end
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
